// File: rtl/core_sequencer.sv
// Fetch/execute sequencer: fetches one instruction, holds it through EXEC, commits or halts.
// Latency: instr latched on imem_ack, EXEC next cycle; stall extends EXEC; no fetch-ack timeout beyond FETCH_TIMEOUT.
module core_sequencer #(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        rd_write_in,
    output logic        rd_write,
    input  logic        stall,
    input  logic        illegal,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc,
    output logic [63:0] instret,
    output logic        halted
);

    localparam int            CW  = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(FETCH_TIMEOUT);
    localparam logic [31:0]   NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t        state, state_nxt;
    logic [63:0]   pc_nxt, instret_nxt;
    logic [31:0]   instr_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt, wait_cnt_inc;
    logic          bad_redirect;

    assign imem_addr    = pc;
    assign wait_cnt_inc = wait_cnt + CW'(1);
    assign bad_redirect = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            instret  <= 64'h0;
            instr    <= NOP;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instret  <= instret_nxt;
            instr    <= instr_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instret_nxt  = instret;
        instr_nxt    = instr;
        wait_cnt_nxt = wait_cnt;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        rd_write     = 1'b0;
        halted       = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    wait_cnt_nxt = '0;
                    state_nxt    = EXEC;
                end else begin
                    wait_cnt_nxt = wait_cnt_inc;
                    if (wait_cnt_inc == TMO) begin
                        state_nxt = HALT;
                    end
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    // illegal and misaligned redirects halt without side effects
                    if (illegal || bad_redirect) begin
                        state_nxt = HALT;
                    end else begin
                        rd_write     = rd_write_in;
                        pc_nxt       = redirect ? redirect_pc : pc + 64'd4;
                        instret_nxt  = instret + 64'd1;
                        wait_cnt_nxt = '0;
                        state_nxt    = FETCH;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
        // Outputs are quiet while reset is held, even though state already reads FETCH.
        if (!rst_n) begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            rd_write    = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: scoreboard of fetch-accept and register-write events plus per-cycle checks.
module tb_core_sequencer;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        rd_write_in = 1'b0;
    logic        rd_write;
    logic        stall = 1'b0;
    logic        illegal = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] pc;
    logic [63:0] instret;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    core_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .rd_write_in(rd_write_in), .rd_write(rd_write),
        .stall(stall), .illegal(illegal), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .instret(instret), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, after inputs have settled and before the next rising edge.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rd_write || (imem_req && imem_ack)) begin
                if (exp_q.size() == 0) begin
                    chk(rd_write ? "unexpected_rd_write" : "unexpected_fetch", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind_is_wr", {63'd0, rd_write}, {63'd0, e.is_wr});
                    if (e.is_wr) begin
                        chk("wr_pc", pc, e.addr);
                        chk("wr_instr", {32'd0, instr}, {32'd0, e.data});
                    end else begin
                        chk("fetch_addr", imem_addr, e.addr);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        stall = 0; rd_write_in = 0; redirect = 0; redirect_pc = 0;
        illegal = 0; imem_ack = 0; imem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        #1;
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_rd_write", {63'd0, rd_write}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instret", instret, 64'd0);
        chk("rst_instr", {32'd0, instr}, {32'd0, NOP});
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("post_rst_imem_req", {63'd0, imem_req}, 64'd1);
        chk("post_rst_addr", imem_addr, RST_PC);
    endtask

    // delay = number of no-ack cycles before the ack cycle
    task automatic fetch(input logic [63:0] exp_addr, input logic [31:0] word, input int delay,
                         input logic [63:0] exp_instret);
        for (int i = 0; i <= delay; i++) begin
            @(negedge clk);
            idle();
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? word : 32'h0BAD_0BAD;
            #1;
            chk("fetch_req", {63'd0, imem_req}, 64'd1);
            chk("fetch_addr_stable", imem_addr, exp_addr);
            chk("fetch_valid", {63'd0, instr_valid}, 64'd0);
            chk("fetch_halted", {63'd0, halted}, 64'd0);
            if (i == 0) chk("fetch_instret", instret, exp_instret);
            if (i == delay) exp_q.push_back('{is_wr: 1'b0, addr: exp_addr, data: 32'h0});
        end
    endtask

    task automatic exec(input int stalls, input logic rdw, input logic redir, input logic [63:0] rpc,
                        input logic ill, input logic [63:0] exp_pc, input logic [31:0] exp_instr,
                        input logic exp_wr);
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            idle();
            stall = 1; rd_write_in = rdw; redirect = redir; redirect_pc = rpc; illegal = ill;
            imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
            #1;
            chk("stall_valid", {63'd0, instr_valid}, 64'd1);
            chk("stall_rd_write", {63'd0, rd_write}, 64'd0);
            chk("stall_instr", {32'd0, instr}, {32'd0, exp_instr});
            chk("stall_pc", pc, exp_pc);
        end
        @(negedge clk);
        idle();
        rd_write_in = rdw; redirect = redir; redirect_pc = rpc; illegal = ill;
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("commit_valid", {63'd0, instr_valid}, 64'd1);
        chk("commit_instr", {32'd0, instr}, {32'd0, exp_instr});
        chk("commit_rd_write", {63'd0, rd_write}, {63'd0, exp_wr});
        if (exp_wr) exp_q.push_back('{is_wr: 1'b1, addr: exp_pc, data: exp_instr});
    endtask

    task automatic halt_check(input logic [63:0] exp_pc, input logic [63:0] exp_instret);
        repeat (3) begin
            @(negedge clk);
            idle();
            imem_ack = 1; rd_write_in = 1;
            #1;
            chk("halt_halted", {63'd0, halted}, 64'd1);
            chk("halt_imem_req", {63'd0, imem_req}, 64'd0);
            chk("halt_valid", {63'd0, instr_valid}, 64'd0);
            chk("halt_rd_write", {63'd0, rd_write}, 64'd0);
            chk("halt_pc", pc, exp_pc);
            chk("halt_instret", instret, exp_instret);
        end
    endtask

    initial begin
        int req_cycles;
        bit saw_halt;
        do_reset();

        // straight-line
        fetch(64'd0,  32'h0010_0093, 0, 64'd0); exec(0, 1, 0, 0, 0, 64'd0,  32'h0010_0093, 1);
        fetch(64'd4,  32'h0020_0113, 0, 64'd1); exec(0, 1, 0, 0, 0, 64'd4,  32'h0020_0113, 1);
        fetch(64'd8,  32'h0030_0193, 0, 64'd2); exec(0, 1, 0, 0, 0, 64'd8,  32'h0030_0193, 1);
        // delayed ack, then stalled EXEC
        fetch(64'd12, 32'h0040_0213, 5, 64'd3); exec(3, 1, 0, 0, 0, 64'd12, 32'h0040_0213, 1);
        // aligned redirect, no-write commit, redirect to top of address space, wrap
        fetch(64'd16, 32'h1000_006F, 0, 64'd4); exec(0, 1, 1, 64'h100, 0, 64'd16, 32'h1000_006F, 1);
        fetch(64'h100, 32'h0000_0063, 0, 64'd5); exec(0, 0, 0, 0, 0, 64'h100, 32'h0000_0063, 0);
        fetch(64'h104, 32'h0050_0293, 0, 64'd6);
        exec(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h104, 32'h0050_0293, 1);
        fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313, 0, 64'd7);
        exec(0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313, 1);
        // misaligned redirect halts
        fetch(64'd0, 32'h0070_0393, 0, 64'd8); exec(0, 1, 1, 64'h102, 0, 64'd0, 32'h0070_0393, 0);
        halt_check(64'd0, 64'd8);

        // illegal wins over redirect
        do_reset();
        fetch(64'd0, 32'hFFFF_FFFF, 0, 64'd0); exec(1, 1, 1, 64'h200, 1, 64'd0, 32'hFFFF_FFFF, 0);
        halt_check(64'd0, 64'd0);

        // fetch timeout: release cycle already showed imem_req high
        do_reset();
        req_cycles = 1;
        saw_halt = 0;
        for (int i = 0; i < 40 && !saw_halt; i++) begin
            @(negedge clk);
            idle();
            #1;
            if (halted) saw_halt = 1;
            else if (imem_req) req_cycles++;
        end
        chk("timeout_halted", {63'd0, saw_halt}, 64'd1);
        chk("timeout_req_cycles", req_cycles, 64'd16);
        chk("timeout_imem_req_off", {63'd0, imem_req}, 64'd0);

        // reset asserted mid-EXEC
        do_reset();
        fetch(64'd0, 32'h0080_0413, 0, 64'd0); exec(0, 1, 0, 0, 0, 64'd0, 32'h0080_0413, 1);
        fetch(64'd4, 32'h0090_0493, 0, 64'd1);
        @(negedge clk);
        idle();
        stall = 1; rd_write_in = 1;
        #1;
        chk("pre_rst_valid", {63'd0, instr_valid}, 64'd1);
        chk("pre_rst_pc", pc, 64'd4);
        #1;
        rst_n = 0;
        #1;
        chk("midexec_rst_pc", pc, RST_PC);
        chk("midexec_rst_instret", instret, 64'd0);
        chk("midexec_rst_instr", {32'd0, instr}, {32'd0, NOP});
        chk("midexec_rst_rd_write", {63'd0, rd_write}, 64'd0);
        chk("midexec_rst_valid", {63'd0, instr_valid}, 64'd0);
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        chk("midexec_release_req", {63'd0, imem_req}, 64'd1);
        chk("midexec_release_addr", imem_addr, RST_PC);

        @(negedge clk);
        #6;
        chk("scoreboard_empty", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the address of the first instruction fetched after reset.
REQ-002 The block SHALL have parameter FETCH_TIMEOUT, default 16, meaning the maximum number of cycles to wait for imem_ack before halting.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, ports listed clock and reset first as follows:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  fetch address (current PC).
- imem_ack  input  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction presented to decode.
- instr_valid  output  1  instr is stable and being executed.
- rd_write_in  input  1  register-write request from decode control.
- rd_write  output  1  gated register-file write strobe.
- stall  input  1  extend the current EXEC cycle.
- illegal  input  1  decode flags instr as illegal.
- redirect  input  1  take redirect_pc instead of PC+4.
- redirect_pc  input  64  branch/jump target.
- pc  output  64  current program counter.
- instret  output  64  retired-instruction count.
- halted  output  1  core stopped.

Function
REQ-004 The FSM SHALL have the states FETCH, EXEC and HALT; reset enters FETCH.
REQ-005 In FETCH, imem_req SHALL be 1, and imem_addr SHALL equal pc and hold stable until imem_ack.
REQ-006 On imem_ack in FETCH, the block SHALL latch imem_rdata into instr and move to EXEC on the next cycle (fetch-to-exec latency 1 cycle after ack).
REQ-007 imem_ack SHALL be ignored in any state other than FETCH.
REQ-008 A wait counter SHALL count FETCH cycles without ack; when it reaches FETCH_TIMEOUT, the block SHALL move to HALT. The counter SHALL clear on ack and on entry to FETCH.
REQ-009 In EXEC, instr_valid SHALL be 1 and instr SHALL be held stable.
REQ-010 EXEC with stall=1 SHALL remain in EXEC with rd_write=0, pc unchanged and instret unchanged.
REQ-011 An EXEC cycle with stall=0 is the commit cycle; a commit cycle with illegal=0 SHALL perform all of the following:
- drive rd_write = rd_write_in;
- set pc to redirect ? redirect_pc : pc+4, modulo 2^64 (wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0);
- increment instret by 1, wrapping at 2^64;
- return to FETCH.
REQ-012 A commit cycle with illegal=1 SHALL perform all of the following:
- rd_write=0;
- pc unchanged;
- instret unchanged;
- go to HALT.
illegal SHALL take priority over redirect.
REQ-013 A commit cycle with redirect=1 and redirect_pc[1:0]!=0 SHALL go to HALT, with rd_write=0, pc unchanged and instret unchanged.
REQ-014 rd_write SHALL be 0 in every cycle other than a legal commit cycle; rd_write SHALL never be asserted twice for one fetched instruction.
REQ-015 In HALT, the block SHALL drive halted=1, imem_req=0, instr_valid=0 and rd_write=0, and SHALL stay in HALT until reset.
REQ-016 While stall=1 in FETCH, stall SHALL have no effect.
REQ-017 The outputs imem_req, instr_valid, rd_write and halted SHALL be combinational functions of state and inputs, with no extra register stage.

Reset
REQ-018 On rst_n low, the following SHALL take effect immediately, independent of clk:
- state=FETCH;
- pc=RESET_PC;
- instret=0;
- instr=32'h0000_0013 (NOP);
- wait counter=0.
REQ-019 While rst_n is low, the outputs SHALL be imem_req=0, instr_valid=0, rd_write=0 and halted=0.
REQ-020 imem_req SHALL assert in the first cycle after rst_n is sampled high.
REQ-021 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the operation with no rd_write pulse, and any pending ack SHALL be dropped.

Verification
REQ-022 The bench SHALL cover at least the following directed scenarios:
- Straight-line: ack every FETCH with rd_write_in=1 -> pc 0,4,8,12; one rd_write pulse per instruction; instret=3 after three commits.
- Ack delayed 5 cycles -> imem_req held with imem_addr constant for 6 cycles; instr equals imem_rdata from the ack cycle; no timeout.
- Stall 3 cycles in EXEC -> instr_valid high for 4 cycles; single rd_write in the 4th cycle; pc advances once.
- redirect=1 with redirect_pc=64'h100 -> next imem_addr=64'h100; redirect_pc=64'h102 -> HALT with pc unchanged.
- illegal=1 together with redirect=1 -> HALT, rd_write=0, instret unchanged; FETCH_TIMEOUT=16 cycles with no ack -> HALT.
- pc=64'hFFFF_FFFF_FFFF_FFFC committed -> pc=0; rst_n pulsed low mid-EXEC -> pc=RESET_PC and instret=0 immediately.
